// File: rtl/pixel_readout_seq.sv
// pixel_readout_seq: per-frame pixel-array sequencer.
// One frame per init request: ERASE (1 cycle), EXPOSE (exposure_time cycles),
// CONVERT (CONV_CYCLES cycles), then READ, which hands out row addresses
// 0..N_ROWS-1 over a valid/ready handshake. Exposure time is adjustable in
// IDLE only and saturates at EXP_MIN/EXP_MAX. Every output is a flop.
// Optional feature macro: PIXEL_READOUT_SEQ_TIMEOUT_EN -- aborts READ with a
// one-cycle read_err pulse after TIMEOUT_CYC consecutive stalled cycles.
module pixel_readout_seq #(
  parameter int ADDR_W      = 3,
  parameter int N_ROWS      = 8,
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_RST     = 15,
  parameter int CONV_CYCLES = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              exp_inc,
  input  logic              exp_dec,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ADDR_W-1:0] row_addr,
  output logic              busy,
  output logic [EXP_W-1:0]  exposure_time,
  output logic              read_err
);

  // One down-counter serves both EXPOSE and CONVERT, so it must hold either load.
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int CNT_W  = (EXP_W > CONV_W) ? EXP_W : CONV_W;

  localparam logic [EXP_W-1:0]  EXP_MIN_V = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0]  EXP_MAX_V = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0]  EXP_RST_V = EXP_W'(EXP_RST);
  localparam logic [CNT_W-1:0]  CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]  row_addr_q, row_addr_d;
  logic               erase_q, erase_d;
  logic               expose_q, expose_d;
  logic               convert_q, convert_d;
  logic               row_valid_q, row_valid_d;
  logic               busy_q, busy_d;

`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               read_err_q, read_err_d;
`endif

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    row_addr_d  = row_addr_q;
    erase_d     = 1'b0;
    expose_d    = 1'b0;
    convert_d   = 1'b0;
    row_valid_d = 1'b0;
`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
    stall_d     = '0;
    read_err_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        row_addr_d = '0;
        if (exp_inc || exp_dec) begin
          // Any adjust request takes priority over init for this cycle.
          if (exp_inc && !exp_dec && (exp_q < EXP_MAX_V)) begin
            exp_d = exp_q + EXP_W'(1);
          end else if (exp_dec && !exp_inc && (exp_q > EXP_MIN_V)) begin
            exp_d = exp_q - EXP_W'(1);
          end else begin
            exp_d = exp_q;
          end
        end else if (init) begin
          // Latch the exposure length on ERASE entry; EXPOSE counts it down to 0.
          state_d = ST_ERASE;
          erase_d = 1'b1;
          cnt_d   = CNT_W'(exp_q) - CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        state_d  = ST_EXPOSE;
        expose_d = 1'b1;
      end
      ST_EXPOSE: begin
        if (cnt_q == '0) begin
          state_d   = ST_CONVERT;
          convert_d = 1'b1;
          cnt_d     = CONV_LOAD;
        end else begin
          expose_d = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        if (cnt_q == '0) begin
          state_d     = ST_READ;
          row_valid_d = 1'b1;
          row_addr_d  = '0;
        end else begin
          convert_d = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      ST_READ: begin
        if (row_ready) begin
          if (row_addr_q == LAST_ROW) begin
            state_d    = ST_IDLE;
            row_addr_d = '0;
          end else begin
            row_valid_d = 1'b1;
            row_addr_d  = row_addr_q + ADDR_W'(1);
          end
        end else begin
`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
          if (stall_q == STALL_LAST) begin
            state_d    = ST_IDLE;
            row_addr_d = '0;
            read_err_d = 1'b1;
          end else begin
            row_valid_d = 1'b1;
            stall_d     = stall_q + STALL_W'(1);
          end
`else
          row_valid_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d    = ST_IDLE;
        row_addr_d = '0;
        cnt_d      = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      exp_q       <= EXP_RST_V;
      row_addr_q  <= '0;
      erase_q     <= 1'b0;
      expose_q    <= 1'b0;
      convert_q   <= 1'b0;
      row_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      row_addr_q  <= row_addr_d;
      erase_q     <= erase_d;
      expose_q    <= expose_d;
      convert_q   <= convert_d;
      row_valid_q <= row_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
  // Stall counter and one-cycle read error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q    <= '0;
      read_err_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      read_err_q <= read_err_d;
    end
  end

  assign read_err = read_err_q;
`else
  assign read_err = 1'b0;
`endif

  assign erase         = erase_q;
  assign expose        = expose_q;
  assign convert       = convert_q;
  assign row_valid     = row_valid_q;
  assign row_addr      = row_addr_q;
  assign busy          = busy_q;
  assign exposure_time = exp_q;

endmodule

// File: tb/tb_pixel_readout_seq.sv
// Self-checking bench for pixel_readout_seq: random stimulus against a
// frame-level reference (phase lengths, transferred row list, saturating
// exposure arithmetic).
module tb_pixel_readout_seq;

  localparam int N_ROWS  = 8;
  localparam int CONV    = 16;
  localparam int EXP_MIN = 2;
  localparam int EXP_MAX = 30;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       init = 1'b0;
  logic       exp_inc = 1'b0;
  logic       exp_dec = 1'b0;
  logic       row_ready = 1'b0;
  logic       erase, expose, convert, row_valid, busy, read_err;
  logic [2:0] row_addr;
  logic [4:0] exposure_time;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_model = 15;

  pixel_readout_seq dut (
    .clk(clk), .reset_n(reset_n), .init(init), .exp_inc(exp_inc),
    .exp_dec(exp_dec), .erase(erase), .expose(expose), .convert(convert),
    .row_valid(row_valid), .row_ready(row_ready), .row_addr(row_addr),
    .busy(busy), .exposure_time(exposure_time), .read_err(read_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive inc/dec for n edges in IDLE, tracking the saturating model.
  task automatic adjust(input logic inc, input logic dec, input int n);
    exp_inc = inc;
    exp_dec = dec;
    for (int i = 0; i < n; i++) begin
      step();
      if (inc && !dec) exp_model = (exp_model < EXP_MAX) ? exp_model + 1 : EXP_MAX;
      else if (dec && !inc) exp_model = (exp_model > EXP_MIN) ? exp_model - 1 : EXP_MIN;
    end
    exp_inc = 1'b0;
    exp_dec = 1'b0;
  endtask

  // Observes one frame from its first busy sample until busy drops.
  // mode 0: ready always, 1: hold row 3 for 5 cycles, 2: random ready.
  task automatic monitor_frame(input int mode, output int busy_n);
    int erase_n, expose_n, conv_n, stalls, guard, phase, ph, bp_left;
    int onehot_bad, order_bad, stable_bad, frozen_bad;
    logic [2:0] rows[$];
    logic [2:0] prev_addr;
    logic       prev_stall, r;
    erase_n = 0; expose_n = 0; conv_n = 0; stalls = 0; guard = 0; phase = 0;
    onehot_bad = 0; order_bad = 0; stable_bad = 0; frozen_bad = 0;
    bp_left = 5; busy_n = 0; prev_stall = 1'b0; prev_addr = 3'd0;
    while (busy === 1'b1 && guard < 3000) begin
      guard++;
      busy_n++;
      if ($countones({erase, expose, convert, row_valid}) != 1) onehot_bad++;
      ph = erase ? 1 : expose ? 2 : convert ? 3 : row_valid ? 4 : 0;
      if (ph < phase) order_bad++;
      phase = ph;
      if (erase) erase_n++;
      if (expose) expose_n++;
      if (convert) conv_n++;
      if (exposure_time !== 5'(exp_model)) frozen_bad++;
      if (prev_stall && row_addr !== prev_addr) stable_bad++;
      if (row_valid) begin
        if (mode == 0) r = 1'b1;
        else if (mode == 1) begin
          if (row_addr == 3'd3 && bp_left > 0) begin
            r = 1'b0;
            bp_left--;
          end else begin
            r = 1'b1;
          end
        end else begin
          r = 1'($urandom_range(0, 1));
        end
        row_ready = r;
        if (r) rows.push_back(row_addr);
        else stalls++;
        prev_stall = ~r;
        prev_addr = row_addr;
      end else begin
        row_ready = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      exp_inc = 1'($urandom_range(0, 1));
      exp_dec = 1'($urandom_range(0, 1));
      step();
    end
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    row_ready = 1'b0;
    tests_run++;
    if (guard >= 3000) begin
      tests_failed++;
      $display("FAIL frame_timeout: busy still %b after %0d cycles, required 0", busy, guard);
    end
    tests_run++;
    if (erase_n != 1 || expose_n != exp_model || conv_n != CONV) begin
      tests_failed++;
      $display("FAIL phase_len: erase=%0d expose=%0d convert=%0d, required 1/%0d/%0d",
               erase_n, expose_n, conv_n, exp_model, CONV);
    end
    tests_run++;
    begin
      int bad;
      bad = (rows.size() != N_ROWS) ? 1 : 0;
      for (int i = 0; i < rows.size() && i < N_ROWS; i++) if (rows[i] !== 3'(i)) bad = 1;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL rows: %0d transfers %p, required 0..%0d in order", rows.size(), rows, N_ROWS - 1);
      end
    end
    tests_run++;
    if (busy_n != 1 + exp_model + CONV + N_ROWS + stalls) begin
      tests_failed++;
      $display("FAIL frame_len: busy %0d cycles, required %0d", busy_n, 1 + exp_model + CONV + N_ROWS + stalls);
    end
    tests_run++;
    if (onehot_bad != 0 || order_bad != 0 || stable_bad != 0 || frozen_bad != 0) begin
      tests_failed++;
      $display("FAIL frame_rules: onehot=%0d order=%0d addr_unstable=%0d exp_changed=%0d, required all 0",
               onehot_bad, order_bad, stable_bad, frozen_bad);
    end
    tests_run++;
    if ({erase, expose, convert, row_valid, read_err} !== 5'b0 || row_addr !== 3'd0 ||
        exposure_time !== 5'(exp_model)) begin
      tests_failed++;
      $display("FAIL frame_end: strobes=%b row_addr=%0d exp=%0d, required 0/0/%0d",
               {erase, expose, convert, row_valid, read_err}, row_addr, exposure_time, exp_model);
    end
  endtask

  task automatic start_frame();
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    tests_run++;
    if ({erase, expose, convert, row_valid, busy, read_err} !== 6'b0 || row_addr !== 3'd0 ||
        exposure_time !== 5'd15) begin
      tests_failed++;
      $display("FAIL reset_values: strobes=%b row_addr=%0d exp=%0d, required 0/0/15",
               {erase, expose, convert, row_valid, busy, read_err}, row_addr, exposure_time);
    end
    reset_n = 1'b1;
    step();
    start_frame();
    repeat (3) step();
    tests_run++;
    if (expose !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_expose: expose=%b busy=%b, required 1/1", expose, busy);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({erase, expose, convert, row_valid, busy, read_err} !== 6'b0 || row_addr !== 3'd0 ||
        exposure_time !== 5'd15) begin
      tests_failed++;
      $display("FAIL reset_mid_expose: strobes=%b row_addr=%0d exp=%0d, required 0/0/15",
               {erase, expose, convert, row_valid, busy, read_err}, row_addr, exposure_time);
    end
    step();
    reset_n = 1'b1;
    exp_model = 15;
    step();
  endtask

  task automatic test_exposure();
    adjust(1'b1, 1'b0, 20);
    tests_run++;
    if (exposure_time !== 5'd30 || exposure_time !== 5'(exp_model)) begin
      tests_failed++;
      $display("FAIL exp_sat_max: got %0d, required 30", exposure_time);
    end
    adjust(1'b0, 1'b1, 40);
    tests_run++;
    if (exposure_time !== 5'd2 || exposure_time !== 5'(exp_model)) begin
      tests_failed++;
      $display("FAIL exp_sat_min: got %0d, required 2", exposure_time);
    end
    adjust(1'b1, 1'b1, 5);
    tests_run++;
    if (exposure_time !== 5'd2) begin
      tests_failed++;
      $display("FAIL exp_inc_dec_both: got %0d, required 2", exposure_time);
    end
    for (int i = 0; i < 30; i++) begin
      adjust(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      tests_run++;
      if (exposure_time !== 5'(exp_model)) begin
        tests_failed++;
        $display("FAIL exp_random[%0d]: got %0d, required %0d", i, exposure_time, exp_model);
      end
    end
    // Adjust together with init: the adjust wins and no frame starts.
    if (exp_model == EXP_MAX) adjust(1'b0, 1'b1, 1);
    init = 1'b1;
    exp_inc = 1'b1;
    step();
    exp_model = exp_model + 1;
    init = 1'b0;
    exp_inc = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b0 || exposure_time !== 5'(exp_model)) begin
      tests_failed++;
      $display("FAIL exp_vs_init: busy=%b exp=%0d, required 0/%0d", busy, exposure_time, exp_model);
    end
  endtask

  task automatic test_nominal();
    int bn;
    adjust(1'b0, 1'b1, 40);
    adjust(1'b1, 1'b0, 2);
    start_frame();
    monitor_frame(0, bn);
    tests_run++;
    if (bn != 29) begin
      tests_failed++;
      $display("FAIL nominal_busy: got %0d busy cycles, required 29", bn);
    end
  endtask

  task automatic test_backpressure();
    int bn;
    adjust(1'b1, 1'b0, $urandom_range(0, 6));
    start_frame();
    monitor_frame(1, bn);
  endtask

  task automatic test_random_frames();
    int bn;
    for (int f = 0; f < 4; f++) begin
      adjust(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      step();
      start_frame();
      monitor_frame(2, bn);
    end
  endtask

  task automatic test_back_to_back();
    int bn;
    init = 1'b1;
    step();
    monitor_frame(2, bn);
    step();
    tests_run++;
    if (erase !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_restart: erase=%b busy=%b, required 1/1", erase, busy);
    end
    monitor_frame(0, bn);
    init = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_stop: busy=%b, required 0", busy);
    end
  endtask

`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int guard, valid_n;
    start_frame();
    guard = 0;
    valid_n = 0;
    row_ready = 1'b0;
    while (row_valid !== 1'b1 && guard < 100) begin
      guard++;
      step();
    end
    guard = 0;
    while (read_err !== 1'b1 && guard < 200) begin
      if (row_valid === 1'b1) valid_n++;
      guard++;
      step();
    end
    tests_run++;
    if (valid_n != 64 || read_err !== 1'b1 || row_valid !== 1'b0 || busy !== 1'b0 || row_addr !== 3'd0) begin
      tests_failed++;
      $display("FAIL timeout: stalled=%0d read_err=%b valid=%b busy=%b addr=%0d, required 64/1/0/0/0",
               valid_n, read_err, row_valid, busy, row_addr);
    end
    step();
    tests_run++;
    if (read_err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: read_err=%b busy=%b, required 0/0", read_err, busy);
    end
  endtask
`else
  task automatic test_stall_hold();
    int guard, bad;
    start_frame();
    guard = 0;
    bad = 0;
    row_ready = 1'b0;
    while (row_valid !== 1'b1 && guard < 100) begin
      guard++;
      step();
    end
    for (int i = 0; i < 200; i++) begin
      if (row_valid !== 1'b1 || read_err !== 1'b0 || row_addr !== 3'd0 || busy !== 1'b1) bad++;
      step();
    end
    tests_run++;
    if (bad != 0 || guard >= 100) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d bad cycles (wait %0d), required 0", bad, guard);
    end
    row_ready = 1'b1;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      guard++;
      step();
    end
    row_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || guard != N_ROWS) begin
      tests_failed++;
      $display("FAIL stall_release: busy=%b after %0d cycles, required 0 after %0d", busy, guard, N_ROWS);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exposure();
    test_nominal();
    test_backpressure();
    test_random_frames();
    test_back_to_back();
`ifdef PIXEL_READOUT_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_stall_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pixel_readout_seq.md
Name: pixel_readout_seq

Overview:
- Sequencer that drives the pixel-array control and row-address side of the camera datapath.
- Runs one frame per start request: ERASE, EXPOSE, CONVERT, then READ.
- In READ it issues row addresses one at a time to the downstream row decoder/readout logic over a valid/ready handshake.
- Holds a user-adjustable, saturating exposure time.

Parameters:
- ADDR_W, 3: row address width.
- N_ROWS, 8: rows per frame, 1..2**ADDR_W.
- EXP_W, 5: exposure register width.
- EXP_MIN, 2: minimum exposure in cycles.
- EXP_MAX, 30: maximum exposure in cycles, must be ≤ 2**EXP_W-1.
- EXP_RST, 15: exposure value after reset.
- CONV_CYCLES, 16: cycles convert is held high, ≥1.
- TIMEOUT_CYC, 64: read stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- init  in  1  frame start request, sampled in IDLE.
- exp_inc  in  1  increment exposure, sampled in IDLE.
- exp_dec  in  1  decrement exposure, sampled in IDLE.
- erase  out  1  pixel erase strobe.
- expose  out  1  pixel exposure enable.
- convert  out  1  ADC/conversion enable.
- row_valid  out  1  row_addr valid.
- row_ready  in  1  downstream accepts row_addr.
- row_addr  out  ADDR_W  current row.
- busy  out  1  high in every state except IDLE.
- exposure_time  out  EXP_W  current exposure setting.
- read_err  out  1  read timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, reset_n=0), applied immediately, including mid-frame:
  - state=IDLE.
  - erase, expose, convert, row_valid, busy, read_err = 0.
  - row_addr=0, exposure_time=EXP_RST.
  - Internal counters = 0.
- All outputs are registered (Moore); no combinational path from any input to any output.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE:
  - init=1 → ERASE on the next edge.
  - exp_inc/exp_dec update exposure_time by 1 per cycle, saturating at EXP_MAX/EXP_MIN.
  - inc and dec both high → no change.
  - exp_inc/exp_dec and init high together → the exposure update wins that cycle, the frame does not start; init is re-sampled next cycle.
- Outside IDLE: init, exp_inc and exp_dec are ignored. exposure_time is frozen for the whole frame.
- ERASE: erase=1 for exactly 1 cycle → EXPOSE.
- EXPOSE:
  - expose=1 for exactly exposure_time cycles (value latched on ERASE entry) → CONVERT.
- CONVERT: convert=1 for exactly CONV_CYCLES cycles → READ with row_addr=0, row_valid=1.
- READ:
  - row_valid=1; row_addr stable while row_ready=0.
  - Transfer = row_valid & row_ready at a rising edge.
  - On a transfer of row k < N_ROWS-1: row_addr=k+1 next cycle, row_valid stays 1 (back-to-back transfers allowed, one row per cycle).
  - On a transfer of row N_ROWS-1: → IDLE, row_valid=0, row_addr=0, busy=0 next cycle.
- Exactly one of erase/expose/convert/row_valid is high at any time; all are low in IDLE.
- Frame length with row_ready tied 1: 1 + exposure_time + CONV_CYCLES + N_ROWS cycles from the first busy cycle to the last.

Optional Feature:
- Macro: PIXEL_READOUT_SEQ_TIMEOUT_EN.
- Defined:
  - In READ, a stall counter counts consecutive cycles with row_valid=1 and row_ready=0; it resets on any transfer.
  - When it reaches TIMEOUT_CYC: state → IDLE, row_valid=0, row_addr=0, and read_err=1 for exactly one cycle.
- Not defined: no counter; read_err is a constant 0; READ waits indefinitely.

Test Plan:
- Reset: reset_n=0 → all strobes 0, busy=0, row_addr=0, exposure_time=15. Assert reset_n=0 mid-EXPOSE → outputs clear without a clock edge.
- Exposure adjust: 20 cycles exp_inc from 15 → saturates at 30. 40 cycles exp_dec → 2. inc+dec together → unchanged. Pulses while busy → no change.
- Nominal frame, row_ready=1, exposure_time=4 → erase 1 cycle, expose 4 cycles, convert 16 cycles, row_addr 0..7 on consecutive cycles, busy low after 29 busy cycles.
- Backpressure: row_ready low for 5 cycles on row 3 → row_addr holds 3 with row_valid=1. Release → rows 4..7 follow, 8 transfers total, no duplicated or skipped addresses.
- init held continuously for 2 frames → second ERASE starts exactly 1 cycle after the IDLE entry. init while busy → no effect on the current frame.
- With PIXEL_READOUT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=64: row_ready=0 in READ → read_err single pulse after 64 stalled cycles, then IDLE. Without the macro → READ held indefinitely, read_err=0.
